// File: rtl/bloom_pkg.sv
// Shared types and hash constants for the Bloom-filter instruction sequencer.
package bloom_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_INSERT = 2'b01,
    OP_CHECK  = 2'b10,
    OP_CLEAR  = 2'b11
  } bloom_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDAT,
    ST_WR,
    ST_CLR,
    ST_RESP
  } bloom_state_e;

  localparam logic [31:0] HASH_C0 = 32'h9E37_79B1;
  localparam logic [31:0] HASH_C1 = 32'h85EB_CA77;
  localparam logic [31:0] HASH_C2 = 32'hC2B2_AE3D;
  localparam logic [31:0] HASH_C3 = 32'h27D4_EB2F;

  function automatic logic [31:0] hash_const(input logic [1:0] k);
    case (k)
      2'd0:    return HASH_C0;
      2'd1:    return HASH_C1;
      2'd2:    return HASH_C2;
      default: return HASH_C3;
    endcase
  endfunction

endpackage

// File: rtl/bloom_hash.sv
// Multiply-shift hash: bit index is the top log2(NUM_BITS) bits of the low 32-bit product.
module bloom_hash import bloom_pkg::*; #(
  parameter int NUM_BITS = 1024
) (
  input  logic [31:0]                   key,
  input  logic [1:0]                    k,
  output logic [$clog2(NUM_BITS)-1:0]   idx
);

  localparam int IDX_W = $clog2(NUM_BITS);

  logic [31:0] prod;

  assign prod = key * hash_const(k);
  assign idx  = IDX_W'(prod >> (32 - IDX_W));

endmodule

// File: rtl/bloom_ctrl.sv
// Bloom-filter sequencer: hashes a key and performs per-index read-modify-write on external word RAM.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read the word holding index k
// RDAT  | read data returned; accumulate hit, keep word for RMW
// WR    | write back word with bit k set (INSERT only)
// CLR   | zero one word per cycle across the array
// RESP  | one-cycle result pulse
module bloom_ctrl import bloom_pkg::*; #(
  parameter int NUM_BITS = 1024,
  parameter int WORD_W   = 32,
  parameter int NUM_HASH = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [1:0]                           req_op_i,
  input  logic [31:0]                          req_key_i,
  output logic                                 resp_valid_o,
  output logic [31:0]                          resp_result_o,
  output logic                                 busy_o,
  output logic [15:0]                          num_inserted_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [$clog2(NUM_BITS/WORD_W)-1:0]   mem_addr_o,
  output logic [WORD_W-1:0]                    mem_wdata_o,
  input  logic [WORD_W-1:0]                    mem_rdata_i
);

  localparam int IDX_W  = $clog2(NUM_BITS);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int ADDR_W = $clog2(NUM_BITS/WORD_W);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_BITS/WORD_W - 1);
  localparam logic [1:0]        LAST_K    = 2'(NUM_HASH - 1);

  bloom_state_e        state, state_nxt;
  bloom_op_e           op_q;
  logic [31:0]         key_q;
  logic [1:0]          k_q;
  logic                hit_q;
  logic [WORD_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [15:0]         count_q;

  logic [IDX_W-1:0]    idx;
  logic [ADDR_W-1:0]   word_sel;
  logic [BIT_W-1:0]    bit_sel;
  logic                k_last;
  logic                accept;

  bloom_hash #(.NUM_BITS(NUM_BITS)) u_hash (
    .key (key_q),
    .k   (k_q),
    .idx (idx)
  );

  assign word_sel = idx[IDX_W-1:BIT_W];
  assign bit_sel  = idx[BIT_W-1:0];
  assign k_last   = (k_q == LAST_K);
  assign accept   = (state == ST_IDLE) && req_valid_i;

  always_comb begin
    state_nxt     = state;
    req_ready_o   = 1'b0;
    resp_valid_o  = 1'b0;
    resp_result_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          case (bloom_op_e'(req_op_i))
            OP_INSERT, OP_CHECK: state_nxt = ST_RD;
            OP_CLEAR:            state_nxt = ST_CLR;
            default:             state_nxt = ST_RESP;
          endcase
        end
      end
      ST_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = word_sel;
        state_nxt  = ST_RDAT;
      end
      ST_RDAT: begin
        if (op_q == OP_INSERT) state_nxt = ST_WR;
        else if (k_last)       state_nxt = ST_RESP;
        else                   state_nxt = ST_RD;
      end
      ST_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_sel;
        mem_wdata_o = rdata_q | (WORD_W'(1) << bit_sel);
        state_nxt   = k_last ? ST_RESP : ST_RD;
      end
      ST_CLR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = clr_addr_q;
        state_nxt  = (clr_addr_q == LAST_WORD) ? ST_RESP : ST_CLR;
      end
      ST_RESP: begin
        resp_valid_o  = 1'b1;
        resp_result_o = {31'b0, hit_q && (op_q == OP_INSERT || op_q == OP_CHECK)};
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      op_q       <= OP_NOP;
      key_q      <= '0;
      k_q        <= '0;
      hit_q      <= 1'b0;
      rdata_q    <= '0;
      clr_addr_q <= '0;
      count_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= bloom_op_e'(req_op_i);
        key_q      <= req_key_i;
        k_q        <= '0;
        hit_q      <= 1'b1;
        clr_addr_q <= '0;
      end
      case (state)
        ST_RDAT: begin
          hit_q   <= hit_q & mem_rdata_i[bit_sel];
          rdata_q <= mem_rdata_i;
          if (op_q == OP_CHECK && !k_last) k_q <= k_q + 2'd1;
        end
        ST_WR:   if (!k_last) k_q <= k_q + 2'd1;
        ST_CLR:  clr_addr_q <= clr_addr_q + ADDR_W'(1);
        ST_RESP: begin
          if (op_q == OP_CLEAR) count_q <= '0;
          else if (op_q == OP_INSERT && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o         = (state != ST_IDLE);
  assign num_inserted_o = count_q;

endmodule

// File: doc/bloom_ctrl.md
Name: bloom_ctrl

Overview:
- Sequencer for the Bloom-filter custom instruction.
- Accepts one INSERT, CHECK or CLEAR operation at a time from the Ibex custom-instruction issue logic.
- Computes NUM_HASH bit indices from a 32-bit key. It performs read-modify-write on a word-organised bit-array memory, one index at a time, and returns a 32-bit result to the writeback path.
- Owns all sequencing, so the bit array stays a plain single-port synchronous RAM.

Parameters:
- NUM_BITS, 1024: Bloom array size in bits. Power of 2, 64..65536.
- WORD_W, 32: memory word width. Power of 2, no larger than NUM_BITS.
- NUM_HASH, 3: hash functions per key, 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  operation request.
- req_ready_o  out  1  controller can accept a request. High only in IDLE.
- req_op_i  in  2  operation code: 00 NOP, 01 INSERT, 10 CHECK, 11 CLEAR.
- req_key_i  in  32  key (rs1 data).
- resp_valid_o  out  1  one-cycle result pulse.
- resp_result_o  out  32  result, zero-extended.
- busy_o  out  1  high in any state other than IDLE.
- num_inserted_o  out  16  saturating count of INSERTs since the last CLEAR or reset.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  log2(NUM_BITS/WORD_W)  word address.
- mem_wdata_o  out  WORD_W  write data.
- mem_rdata_i  in  WORD_W  read data, valid the cycle after a read request.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - FSM goes to IDLE.
  - req_ready_o = 1.
  - resp_valid_o, busy_o, mem_req_o, mem_we_o = 0.
  - resp_result_o, mem_addr_o, mem_wdata_o = 0.
  - num_inserted_o = 0.
  - Array contents are not touched. Software must issue CLEAR after reset.
- Handshake:
  - A request is accepted when req_valid_i && req_ready_o.
  - Op and key are registered at acceptance, so the inputs may change afterwards.
  - There is no response backpressure.
- Hash: idx_k = (key * C_k)[31:32-log2(NUM_BITS)], i.e. the top bits of the low 32-bit product.
  - word = idx_k / WORD_W, bit = idx_k % WORD_W.
  - One index is computed per k, combinationally from the registered key.
- FSM states: IDLE, RD, RDAT, WR, CLR, RESP.
  - IDLE → RD on INSERT or CHECK (k=0, hit=1).
  - IDLE → CLR on CLEAR (addr=0).
  - IDLE → RESP on NOP.
  - RD: mem_req_o=1, mem_we_o=0, addr = word(idx_k). Then → RDAT.
  - RDAT: hit &= mem_rdata_i[bit].
    - INSERT → WR.
    - CHECK: if k = NUM_HASH-1 → RESP, otherwise k++ and → RD.
  - WR: mem_req_o=1, mem_we_o=1, wdata = rdata_q | (1 << bit). INSERT always writes, even when the bit is already set. Then → RESP if k = NUM_HASH-1, otherwise k++ and → RD.
  - CLR: write 0 to addr, addr++. After the last word (NUM_BITS/WORD_W - 1) → RESP.
  - RESP: resp_valid_o=1 for one cycle, then → IDLE.
- Results:
  - CHECK: hit (1 = possibly present, 0 = definitely absent).
  - INSERT: hit before insertion (1 = was already possibly present).
  - CLEAR: 0. NOP: 0.
- num_inserted_o:
  - Increments in RESP of an INSERT, saturating at 0xFFFF.
  - Cleared in RESP of a CLEAR.
- Latency from the accept edge to the resp_valid_o cycle (fixed, data-independent):
  - CHECK: 2*NUM_HASH+1.
  - INSERT: 3*NUM_HASH+1.
  - CLEAR: NUM_BITS/WORD_W + 1.
  - NOP: 1.
- Index collisions: two indices in the same word are correct because each RMW completes before the next read. The memory must return newly written data on a read in the following cycle.
- A request presented while busy is not accepted and is held by the requester. The controller keeps no queue.
- rdata is captured only in RDAT and ignored in all other states.
- Reset mid-operation: immediate return to IDLE and all memory strobes drop asynchronously. A partially written INSERT may leave some bits set; this is acceptable for a Bloom filter. A partial CLEAR leaves the array undefined until CLEAR is reissued.

Decomposition:
- Package bloom_pkg holds:
  - bloom_op_e (NOP/INSERT/CHECK/CLEAR).
  - bloom_state_e.
  - Hash constants C_0..C_3 = 0x9E3779B1, 0x85EBCA77, 0xC2B2AE3D, 0x27D4EB2F.
- One sub-module, bloom_hash: combinational multiply-shift taking key and k and producing idx, parameterised by NUM_BITS.
- Everything else lives in bloom_ctrl. No memory inside the block.

Test Plan:
- Reset, then CLEAR → 33 cycles later resp_valid_o=1, result 0. 32 writes of 0 to addresses 0..31. num_inserted_o=0.
- CHECK key=1 on the cleared array → resp at accept+7, result 0. Reads hit words 19, 16, 24; bits probed 24, 23, 10. No writes.
- INSERT key=1 → resp at accept+10, result 0. Writes of 0x01000000 to word 19, 0x00800000 to word 16, 0x00000400 to word 24. num_inserted_o=1. Repeating INSERT key=1 → result 1, num_inserted_o=2.
- INSERT key=0 → all three indices are 0, i.e. word 0 bit 0, hit three times. Sequential RMW: the final word-0 value is 0x1 and the result is 0. The following CHECK key=0 → 1.
- Hold req_valid_i high with a second CHECK during a busy INSERT → req_ready_o=0 and not accepted until the cycle after the INSERT's resp_valid_o. Then accepted and completed correctly.
- Assert rst_ni=0 in the WR state of an INSERT → same-cycle mem_req_o=0, busy_o=0, resp_valid_o never pulses. After release, the FSM is in IDLE with req_ready_o=1.
